axist_keep_to_avst_sb: RTL and testbench

Pipelined AXI-Stream to Avalon-ST sideband converter for the `axist_to_avst_bridge` path. It converts per-beat `tkeep` into Avalon `empty`, generates `startofpacket`/`endofpacket`, and checks that `tkeep` is legal. It also provides full-rate ready/valid buffering, so the bridge can absorb Avalon backpressure without a combinational ready path. It sits between the AXI-ST ingress and the Avalon-ST egress of the bridge.

---
 rtl/axist_keep_to_avst_sb.sv | 154 +++++++++++++++
 tb/tb_axist_keep_to_avst_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axist_keep_to_avst_sb.sv
// AXI-Stream to Avalon-ST sideband converter: tkeep -> empty, sop/eop generation,
// keep legality checking and a two-entry skid buffer with a registered s_tready.
module axist_keep_to_avst_sb #(
  parameter int unsigned NO_OF_BYTES = 8,
  parameter int unsigned EMPTY_BITS  = 3,
  parameter int unsigned USER_W      = 1,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*NO_OF_BYTES-1:0]   s_tdata,
  input  logic [NO_OF_BYTES-1:0]     s_tkeep,
  input  logic                       s_tlast,
  input  logic [USER_W-1:0]          s_tuser,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [8*NO_OF_BYTES-1:0]   m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_sop,
  output logic                       m_eop,
  output logic [EMPTY_BITS-1:0]      m_empty,
  output logic                       m_error,
  output logic [USER_W-1:0]          m_user,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  typedef struct packed {
    logic [8*NO_OF_BYTES-1:0] data;
    logic [USER_W-1:0]        user;
    logic                     sop;
    logic                     eop;
    logic [EMPTY_BITS-1:0]    empty;
    logic                     error;
  } beat_t;

  typedef enum logic {EXPECT_SOP, IN_PKT} state_t;

  localparam logic [NO_OF_BYTES-1:0] KEEP_ONE = {{(NO_OF_BYTES-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   sticky_q;
  logic                   ready_q;
  logic                   out_valid_q, skid_valid_q, skid_valid_d;
  beat_t                  out_q, skid_q, in_beat;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic [EMPTY_BITS:0]    zcnt;
  logic                   keep_all, keep_zero, keep_contig, viol;
  logic                   accept, out_free;

  assign accept   = s_tvalid & ready_q;
  assign out_free = ~out_valid_q | m_ready;

  // Keep analysis and sideband generation for the beat currently on the input.
  always_comb begin
    zcnt = '0;
    for (int unsigned i = 0; i < NO_OF_BYTES; i++) begin
      zcnt = zcnt + {{EMPTY_BITS{1'b0}}, ~s_tkeep[i]};
    end
    keep_all    = &s_tkeep;
    keep_zero   = ~|s_tkeep;
    keep_contig = ~keep_zero && ((s_tkeep & (s_tkeep + KEEP_ONE)) == '0);
    viol        = s_tlast ? ~keep_contig : ~keep_all;

    in_beat      = '0;
    in_beat.data = s_tdata;
    in_beat.user = s_tuser;
    in_beat.sop  = (state_q == EXPECT_SOP);
    in_beat.eop  = s_tlast;
    if (s_tlast) begin
      in_beat.error = sticky_q | viol;
      if (keep_zero) begin
        in_beat.empty = EMPTY_BITS'(NO_OF_BYTES - 1);
      end else begin
        in_beat.empty = zcnt[EMPTY_BITS-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EXPECT_SOP: if (accept && !s_tlast) state_d = IN_PKT;
      IN_PKT:     if (accept && s_tlast)  state_d = EXPECT_SOP;
      default:    state_d = EXPECT_SOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXPECT_SOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Skid holds a beat only while the output register is stalled; ready is the
  // registered inverse of the next skid occupancy so it never depends on m_ready.
  always_comb begin
    if (skid_valid_q) begin
      skid_valid_d = ~out_free;
    end else begin
      skid_valid_d = accept & ~out_free;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
      sticky_q     <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      ready_q      <= ~skid_valid_d;
      skid_valid_q <= skid_valid_d;

      if (accept) begin
        sticky_q <= s_tlast ? 1'b0 : (sticky_q | viol);
      end

      if (out_free) begin
        if (skid_valid_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else if (accept) begin
          out_q       <= in_beat;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= in_beat;
      end

      if (out_valid_q && m_ready && out_q.eop && out_q.error && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign s_tready = ready_q;
  assign m_valid  = out_valid_q;
  assign m_data   = out_q.data;
  assign m_user   = out_q.user;
  assign m_sop    = out_q.sop;
  assign m_eop    = out_q.eop;
  assign m_empty  = out_q.empty;
  assign m_error  = out_q.error;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_axist_keep_to_avst_sb.sv
// Directed bench for axist_keep_to_avst_sb; a second instance with a 2-bit
// error counter shares the stimulus to exercise counter saturation.
module tb_axist_keep_to_avst_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sop, m_eop, m_error;
  logic [2:0]  m_empty;
  logic [0:0]  m_user;
  logic [15:0] err_cnt;

  logic        s_tready2, m_valid2, m_sop2, m_eop2, m_error2;
  logic [63:0] m_data2;
  logic [2:0]  m_empty2;
  logic [0:0]  m_user2;
  logic [1:0]  err_cnt2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  axist_keep_to_avst_sb #(
    .NO_OF_BYTES(8), .EMPTY_BITS(3), .USER_W(1), .ERR_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
    .m_empty(m_empty), .m_error(m_error), .m_user(m_user), .err_cnt(err_cnt)
  );

  axist_keep_to_avst_sb #(
    .NO_OF_BYTES(8), .EMPTY_BITS(3), .USER_W(1), .ERR_CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready2), .m_data(m_data2),
    .m_valid(m_valid2), .m_ready(m_ready), .m_sop(m_sop2), .m_eop(m_eop2),
    .m_empty(m_empty2), .m_error(m_error2), .m_user(m_user2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] keep, input logic last, input logic [63:0] data);
    s_tvalid = 1'b1;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tdata  = data;
    s_tuser  = data[0];
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
  endtask

  task automatic exp_beat(input string tag, input logic sop, input logic eop,
                          input logic [2:0] empty, input logic error, input logic [63:0] data);
    chk({tag, "_valid"}, 64'(m_valid), 64'd1);
    chk({tag, "_sop"},   64'(m_sop),   64'(sop));
    chk({tag, "_eop"},   64'(m_eop),   64'(eop));
    chk({tag, "_empty"}, 64'(m_empty), 64'(empty));
    chk({tag, "_error"}, 64'(m_error), 64'(error));
    chk({tag, "_data"},  m_data,       data);
    chk({tag, "_user"},  64'(m_user),  64'(data[0]));
  endtask

  // Single-beat packet through the pipe at full rate, then checks the idle cycle after.
  task automatic single(input string tag, input logic [7:0] keep, input logic [63:0] data,
                        input logic [2:0] empty, input logic error);
    drive(keep, 1'b1, data);
    step();
    idle();
    exp_beat(tag, 1'b1, 1'b1, empty, error, data);
    step();
    chk({tag, "_idle"}, 64'(m_valid), 64'd0);
  endtask

  logic [63:0] bp_data [6];
  int unsigned iidx, oidx, first_drop;
  logic        in_fire, out_fire;

  initial begin
    rst = 1'b1;
    m_ready = 1'b1;
    idle();
    step();
    step();
    chk("rst_m_valid",  64'(m_valid),  64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_err_cnt",  64'(err_cnt),  64'd0);
    chk("rst_m_sop",    64'(m_sop),    64'd0);
    chk("rst_m_data",   m_data,        64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(s_tready), 64'd1);

    single("single", 8'h07, 64'h0123_4567_89ab_cdef, 3'd5, 1'b0);

    // Three-beat packet, one beat per cycle.
    drive(8'hFF, 1'b0, 64'h1000_0000_0000_0000);
    step();
    exp_beat("p3_b0", 1'b1, 1'b0, 3'd0, 1'b0, 64'h1000_0000_0000_0000);
    drive(8'hFF, 1'b0, 64'h2000_0000_0000_0001);
    step();
    exp_beat("p3_b1", 1'b0, 1'b0, 3'd0, 1'b0, 64'h2000_0000_0000_0001);
    drive(8'h0F, 1'b1, 64'h3000_0000_0000_0002);
    step();
    idle();
    exp_beat("p3_b2", 1'b0, 1'b1, 3'd4, 1'b0, 64'h3000_0000_0000_0002);
    step();

    // Mid-packet keep violation surfaces on the eop beat only.
    drive(8'h7F, 1'b0, 64'h4444_0000_0000_0000);
    step();
    exp_beat("mid_b0", 1'b1, 1'b0, 3'd0, 1'b0, 64'h4444_0000_0000_0000);
    drive(8'hFF, 1'b1, 64'h4444_0000_0000_0001);
    step();
    idle();
    exp_beat("mid_b1", 1'b0, 1'b1, 3'd0, 1'b1, 64'h4444_0000_0000_0001);
    step();
    chk("mid_err_cnt", 64'(err_cnt), 64'd1);

    single("noncontig", 8'h5F, 64'h5555_0000_0000_0000, 3'd2, 1'b1);
    chk("noncontig_err_cnt", 64'(err_cnt), 64'd2);
    single("zero_keep", 8'h00, 64'h6666_0000_0000_0000, 3'd7, 1'b1);
    chk("zero_err_cnt", 64'(err_cnt), 64'd3);
    single("clean_after", 8'hFF, 64'h7777_0000_0000_0001, 3'd0, 1'b0);
    chk("clean_err_cnt", 64'(err_cnt), 64'd3);
    single("err4", 8'h00, 64'h8888_0000_0000_0000, 3'd7, 1'b1);
    single("err5", 8'h01, 64'h9999_0000_0000_0000, 3'd7, 1'b0);
    single("err5b", 8'h03, 64'h9999_0000_0000_0001, 3'd6, 1'b0);
    single("err5c", 8'hF0, 64'h9999_0000_0000_0002, 3'd4, 1'b1);
    chk("err_cnt_5", 64'(err_cnt), 64'd5);
    chk("sat_err_cnt", 64'(err_cnt2), 64'd3);

    // Backpressure: m_ready low for the first 5 cycles of a 6-beat stream.
    for (int i = 0; i < 6; i++) bp_data[i] = 64'hB000_0000_0000_0000 + 64'(i);
    iidx = 0;
    oidx = 0;
    first_drop = 99;
    drive(8'hFF, 1'b0, bp_data[0]);
    for (int c = 0; c < 40 && oidx < 6; c++) begin
      m_ready = (c >= 5);
      #0;
      if (!s_tready && first_drop == 99) first_drop = c;
      if (c >= 1 && c <= 4) begin
        chk("bp_hold_valid", 64'(m_valid), 64'd1);
        chk("bp_hold_data",  m_data,       bp_data[0]);
        chk("bp_hold_sop",   64'(m_sop),   64'd1);
      end
      in_fire  = s_tvalid & s_tready;
      out_fire = m_valid & m_ready;
      if (out_fire) begin
        chk("bp_out_data", m_data,       bp_data[oidx]);
        chk("bp_out_sop",  64'(m_sop),   64'(oidx == 0));
        chk("bp_out_eop",  64'(m_eop),   64'(oidx == 5));
        oidx++;
      end
      step();
      if (in_fire) begin
        iidx++;
        if (iidx < 6) drive(8'hFF, iidx == 5, bp_data[iidx]);
        else idle();
      end
    end
    chk("bp_out_count", 64'(oidx), 64'd6);
    chk("bp_ready_drop_cycle", 64'(first_drop), 64'd2);
    idle();
    step();

    // Reset mid-packet with the output stalled and a sticky error pending.
    m_ready = 1'b0;
    drive(8'h7F, 1'b0, 64'hC000_0000_0000_0000);
    step();
    drive(8'hFF, 1'b0, 64'hC000_0000_0000_0001);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid",   64'(m_valid),  64'd0);
    chk("mid_rst_ready",   64'(s_tready), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt),  64'd0);
    m_ready = 1'b1;
    step();
    chk("mid_rst_valid2",  64'(m_valid),  64'd0);
    chk("mid_rst_ready2",  64'(s_tready), 64'd1);
    single("after_rst", 8'hFF, 64'hD000_0000_0000_0001, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
